// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the shared system bus. Six controllers raise BR,
//   and at most one of them sees its BG bit high. A one-cycle turnaround
//   separates consecutive owners so that tri-state drivers never overlap. A
//   hold watchdog revokes a grant that has been held for MAX_HOLD cycles.
//
// Handshake: BR[i] is a level request from the controller with MY_ID == i.
//   It is held for the whole transaction. BG[i] high means that controller
//   owns the bus. The owner ends its tenure by dropping BR[i]; BG falls after
//   the edge that samples the drop. A revoked controller is ignored until it
//   has been seen with BR[i] low for at least one edge.
//
// Ports:
//   BUS_CLK    in   bus clock, rising edge
//   RST        in   synchronous active-high reset
//   BR[5:0]    in   bus requests
//   BG[5:0]    out  one-hot (or zero) bus grants, registered
//   GRANT_ID   out  current owner index, 0 when not busy, registered
//   BUS_BUSY   out  high while any BG bit is high, registered
//   TIMEOUT    out  one-cycle pulse in the turnaround after a revoke
//   DBG_STATE  out  FSM state (0 IDLE, 1 GRANT, 2 TURN)
//   DBG_PTR    out  round-robin pointer (highest-priority index)
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int N_MASTERS = 6,
   parameter int MAX_HOLD  = 64
) (
   input  logic                 BUS_CLK,
   input  logic                 RST,
   input  logic [N_MASTERS-1:0] BR,
   output logic [N_MASTERS-1:0] BG,
   output logic [2:0]           GRANT_ID,
   output logic                 BUS_BUSY,
   output logic                 TIMEOUT,
   output logic [1:0]           DBG_STATE,
   output logic [2:0]           DBG_PTR
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam logic [7:0]           HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [N_MASTERS-1:0] ONE       = N_MASTERS'(1);

   state_t                 state_q;
   logic [2:0]             owner_q;
   logic [2:0]             ptr_q;
   logic [7:0]             hcnt_q;
   logic [N_MASTERS-1:0]   rmask_q;
   logic [N_MASTERS-1:0]   rmask_d;
   logic [N_MASTERS-1:0]   bg_q;
   logic [2:0]             grant_id_q;
   logic                   busy_q;
   logic                   timeout_q;

   logic [N_MASTERS-1:0]   req;
   logic                   win_found;
   logic [2:0]             win_id;
   logic [2:0]             win_next;
   logic [3:0]             scan_idx;

   // Revoke bits fall on any edge where the master is seen idle.
   assign rmask_d = rmask_q & BR;

   // Scan ptr, ptr+1, ... wrapping at 6; the first eligible requester wins.
   always_comb begin
      req       = BR & ~rmask_q;
      win_found = 1'b0;
      win_id    = 3'd0;
      scan_idx  = 4'd0;
      for (int k = 0; k < N_MASTERS; k++) begin
         scan_idx = {1'b0, ptr_q} + 4'(k);
         if (scan_idx >= 4'(N_MASTERS)) begin
            scan_idx = scan_idx - 4'(N_MASTERS);
         end
         if (!win_found && req[scan_idx[2:0]]) begin
            win_found = 1'b1;
            win_id    = scan_idx[2:0];
         end
      end
      win_next = (win_id == 3'(N_MASTERS - 1)) ? 3'd0 : win_id + 3'd1;
   end

   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         owner_q    <= 3'd0;
         ptr_q      <= 3'd0;
         hcnt_q     <= 8'd0;
         rmask_q    <= '0;
         bg_q       <= '0;
         grant_id_q <= 3'd0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         rmask_q   <= rmask_d;
         timeout_q <= 1'b0;
         case (state_q)
            // IDLE and TURN share the arbitration step; TURN only differs
            // in that it was entered straight from a grant.
            IDLE, TURN: begin
               if (win_found) begin
                  state_q    <= GRANT;
                  owner_q    <= win_id;
                  hcnt_q     <= 8'd0;
                  ptr_q      <= win_next;
                  bg_q       <= ONE << win_id;
                  grant_id_q <= win_id;
                  busy_q     <= 1'b1;
               end else begin
                  state_q    <= IDLE;
                  bg_q       <= '0;
                  grant_id_q <= 3'd0;
                  busy_q     <= 1'b0;
               end
            end
            GRANT: begin
               if (!BR[owner_q]) begin
                  state_q    <= TURN;
                  bg_q       <= '0;
                  grant_id_q <= 3'd0;
                  busy_q     <= 1'b0;
               end else if (hcnt_q == HOLD_LAST) begin
                  // Owner still requesting after MAX_HOLD cycles: revoke and
                  // block it until it drops BR for an edge.
                  state_q    <= TURN;
                  timeout_q  <= 1'b1;
                  rmask_q    <= rmask_d | (ONE << owner_q);
                  bg_q       <= '0;
                  grant_id_q <= 3'd0;
                  busy_q     <= 1'b0;
               end else begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            default: begin
               state_q    <= IDLE;
               bg_q       <= '0;
               grant_id_q <= 3'd0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign BG        = bg_q;
   assign GRANT_ID  = grant_id_q;
   assign BUS_BUSY  = busy_q;
   assign TIMEOUT   = timeout_q;
   assign DBG_STATE = state_q;
   assign DBG_PTR   = ptr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed scenarios followed by randomized request traffic. A behavioural
//   model tracks who owns the bus, how long it has held it, which masters are
//   blocked after a revoke, and who has priority next; DUT outputs are
//   compared with it on every falling edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int NM       = 6;
   localparam int MAX_HOLD = 64;

   // ---------------- clock / reset ----------------
   logic          BUS_CLK = 1'b0;
   logic          RST     = 1'b1;
   logic [NM-1:0] BR      = '0;
   logic [NM-1:0] BG;
   logic [2:0]    GRANT_ID;
   logic          BUS_BUSY;
   logic          TIMEOUT;
   logic [1:0]    DBG_STATE;
   logic [2:0]    DBG_PTR;

   always #5 BUS_CLK = ~BUS_CLK;

   bus_arbiter #(.N_MASTERS(NM), .MAX_HOLD(MAX_HOLD)) dut (
      .BUS_CLK   (BUS_CLK),
      .RST       (RST),
      .BR        (BR),
      .BG        (BG),
      .GRANT_ID  (GRANT_ID),
      .BUS_BUSY  (BUS_BUSY),
      .TIMEOUT   (TIMEOUT),
      .DBG_STATE (DBG_STATE),
      .DBG_PTR   (DBG_PTR)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string name, int got, int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
   endfunction

   function automatic logic [NM-1:0] oh(int i);
      logic [NM-1:0] one;
      one = NM'(1);
      return one << i;
   endfunction

   // ---------------- behavioural model ----------------
   // m_owner: -1 when nobody holds the bus; m_held: cycles BG has been high;
   // m_blk: masters blocked by a revoke; m_next: highest-priority index;
   // m_turn: the bus was just given up on this edge.
   int            m_owner = -1;
   int            m_held  = 0;
   int            m_next  = 0;
   logic [NM-1:0] m_blk   = '0;
   logic          m_turn  = 1'b0;
   logic          m_to    = 1'b0;
   logic [NM-1:0] br_s;

   always @(posedge BUS_CLK) begin
      br_s = BR;
      if (RST) begin
         m_owner = -1; m_held = 0; m_next = 0; m_blk = '0;
         m_turn  = 1'b0; m_to = 1'b0;
      end else begin
         m_turn = 1'b0;
         m_to   = 1'b0;
         if (m_owner >= 0) begin
            if (!br_s[m_owner]) begin
               m_owner = -1; m_turn = 1'b1;
            end else if (m_held == MAX_HOLD) begin
               m_blk[m_owner] = 1'b1;
               m_owner = -1; m_turn = 1'b1; m_to = 1'b1;
            end else begin
               m_held++;
            end
         end else begin
            for (int k = 0; k < NM; k++) begin
               int i;
               i = (m_next + k) % NM;
               if (m_owner < 0 && br_s[i] && !m_blk[i]) begin
                  m_owner = i; m_held = 1; m_next = (i + 1) % NM;
               end
            end
         end
         m_blk = m_blk & br_s;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge BUS_CLK) begin
      int exp_state;
      exp_state = (m_owner >= 0) ? 1 : (m_turn ? 2 : 0);
      chk("bg",       int'(BG),        (m_owner >= 0) ? int'(oh(m_owner)) : 0);
      chk("grant_id", int'(GRANT_ID),  (m_owner >= 0) ? m_owner : 0);
      chk("bus_busy", int'(BUS_BUSY),  (m_owner >= 0) ? 1 : 0);
      chk("timeout",  int'(TIMEOUT),   int'(m_to));
      chk("ptr",      int'(DBG_PTR),   m_next);
      chk("state",    int'(DBG_STATE), exp_state);
      chk("bg_onehot0", int'($onehot0(BG)), 1);
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(int n);
      repeat (n) @(negedge BUS_CLK);
   endtask

   task automatic do_reset();
      @(negedge BUS_CLK);
      RST = 1'b1;
      BR  = '0;
      @(negedge BUS_CLK);
      RST = 1'b0;
      chk("rst_bg",   int'(BG), 0);
      chk("rst_busy", int'(BUS_BUSY), 0);
      chk("rst_id",   int'(GRANT_ID), 0);
      chk("rst_to",   int'(TIMEOUT), 0);
      chk("rst_ptr",  int'(DBG_PTR), 0);
   endtask

   // Advance until some BG bit is high (bounded); returns its index or -1.
   task automatic wait_grant(output int id);
      int n;
      n  = 0;
      id = -1;
      while (BG == '0 && n < 20) begin
         @(negedge BUS_CLK);
         n++;
      end
      for (int i = 0; i < NM; i++) if (BG[i]) id = i;
      if (id < 0) chk("grant_wait_expired", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};

   initial begin
      int id;
      int cnt;
      bit done;

      // Single requester, five-cycle tenure.
      do_reset();
      BR = 6'b000100;
      for (int k = 0; k < 5; k++) begin
         @(negedge BUS_CLK);
         chk("t1_bg", int'(BG), 4);
         chk("t1_id", int'(GRANT_ID), 2);
      end
      BR = '0;
      @(negedge BUS_CLK);
      chk("t1_release", int'(BG), 0);
      chk("t1_ptr", int'(DBG_PTR), 3);
      cyc(2);

      // Full contention, each owner releases after three cycles.
      do_reset();
      BR = 6'b111111;
      for (int g = 0; g < 7; g++) begin
         wait_grant(id);
         chk("t2_order", id, exp_order[g]);
         if (id >= 0) begin
            for (int k = 0; k < 2; k++) begin
               @(negedge BUS_CLK);
               chk("t2_len", int'(BG), int'(oh(id)));
            end
            BR[id] = 1'b0;
            @(negedge BUS_CLK);
            chk("t2_dead", int'(BG), 0);
            BR[id] = 1'b1;
         end
      end
      BR = '0;
      cyc(3);

      // Wrap-around from ptr = 5.
      do_reset();
      BR = 6'b010000;
      @(negedge BUS_CLK);
      chk("t3_bg4", int'(BG), 16);
      BR = '0;
      cyc(2);
      chk("t3_ptr5", int'(DBG_PTR), 5);
      BR = 6'b100001;
      @(negedge BUS_CLK);
      chk("t3_bg5", int'(BG), 32);
      chk("t3_ptr0", int'(DBG_PTR), 0);
      BR = 6'b000001;
      @(negedge BUS_CLK);
      chk("t3_turn", int'(BG), 0);
      @(negedge BUS_CLK);
      chk("t3_bg0", int'(BG), 1);
      BR = '0;
      cyc(3);

      // Watchdog: master 1 holds forever, master 3 joins at cycle 10.
      do_reset();
      BR   = 6'b000010;
      cnt  = 0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge BUS_CLK);
         if (i == 10) BR[3] = 1'b1;
         if (BG == 6'b000010) cnt++;
         else if (cnt > 0) done = 1'b1;
      end
      chk("t4_hold_len", cnt, 64);
      chk("t4_timeout", int'(TIMEOUT), 1);
      @(negedge BUS_CLK);
      chk("t4_bg3", int'(BG), 8);
      chk("t4_to_pulse", int'(TIMEOUT), 0);
      @(negedge BUS_CLK);
      BR[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge BUS_CLK);
         chk("t4_blocked", int'(BG), 0);
      end
      BR[1] = 1'b0;
      @(negedge BUS_CLK);
      BR[1] = 1'b1;
      @(negedge BUS_CLK);
      chk("t4_regrant", int'(BG), 2);
      BR = '0;
      cyc(3);

      // Reset in the middle of a grant to master 4.
      do_reset();
      BR = 6'b010000;
      wait_grant(id);
      chk("t5_owner", id, 4);
      BR = 6'b110000;
      cyc(19);
      RST = 1'b1;
      @(negedge BUS_CLK);
      chk("t5_bg",   int'(BG), 0);
      chk("t5_busy", int'(BUS_BUSY), 0);
      chk("t5_to",   int'(TIMEOUT), 0);
      RST = 1'b0;
      @(negedge BUS_CLK);
      chk("t5_first", int'(BG), 16);
      BR = '0;
      cyc(3);

      // Release coinciding with a new request.
      do_reset();
      BR = 6'b000001;
      @(negedge BUS_CLK);
      chk("t6_bg0", int'(BG), 1);
      BR = 6'b000100;
      @(negedge BUS_CLK);
      chk("t6_turn", int'(BG), 0);
      @(negedge BUS_CLK);
      chk("t6_bg2", int'(BG), 4);
      BR = '0;
      cyc(3);

      // Random traffic: busy toggling, then long holds that reach the watchdog.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         int p;
         @(negedge BUS_CLK);
         p   = (c < 1500) ? 20 : 1;
         RST = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 99) < p) BR[i] = ~BR[i];
         end
      end
      RST = 1'b0;
      BR  = '0;
      cyc(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL sim_time_limit: got expired want finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the shared system bus. It collects one bus-request line from each of up to six bus controllers and returns a one-hot grant to each controller's `BG` input. It sits directly upstream of every bus controller. Grants are round-robin, one dead (turnaround) cycle separates consecutive owners so tri-state drivers never overlap, and a hold watchdog revokes grants held too long.

## Interface
Parameters:
- `N_MASTERS`, default 6: number of request/grant pairs. Fixed at 6; it matches the 3-bit `MY_ID` space, with IDs 0–5 used.
- `MAX_HOLD`, default 64: maximum consecutive cycles `BG` may stay high for one owner. Legal range is 1–255.

Ports:
- `BUS_CLK`, input, 1: bus clock. Everything is sampled on its rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `BR`, input, 6: bus requests. `BR[i]` is driven by the controller whose `MY_ID` is i. It is level-held for the whole transaction.
- `BG`, output, 6: bus grants. At most one bit is high. `BG[i]` drives controller i.
- `GRANT_ID`, output, 3: index of the current owner. It is valid only while `BUS_BUSY` is 1 and reads 0 otherwise.
- `BUS_BUSY`, output, 1: high when any `BG` bit is high.
- `TIMEOUT`, output, 1: one-cycle pulse when a grant is revoked by the watchdog.

All outputs are registered.

## Operation
States: IDLE, GRANT, TURN (turnaround).

Registers:
- state
- `owner`[2:0]
- round-robin pointer `ptr`[2:0], the highest-priority index
- hold counter `hcnt`[7:0]
- revoke mask `rmask`[5:0]

Effective request: `req = BR & ~rmask`.

Priority search:
- Scan indices `ptr`, `ptr+1`, … `ptr+5`, wrapping mod 6 (5 wraps to 0).
- The first set bit of `req` wins.
- Index values 6 and 7 never occur in `ptr` or `owner`.

Transitions:

**IDLE**
- If `req != 0`: go to GRANT, set `owner` = winner, set `hcnt` = 0, set `ptr` = (winner+1) mod 6.
- Otherwise stay in IDLE.

**GRANT**
- If `BR[owner]` == 0: go to TURN. This is a normal release.
- Else if `hcnt` == `MAX_HOLD`−1: go to TURN, pulse `TIMEOUT`, set `rmask[owner]` = 1. This is a revoke.
- Otherwise `hcnt` = `hcnt`+1 and stay in GRANT.

**TURN**
- If `req != 0`: go directly to GRANT with a new winner, using the same update as IDLE.
- Otherwise go to IDLE.

Revoke mask:
- `rmask[i]` clears on any edge where `BR[i]` is sampled 0.
- A revoked master must therefore drop `BR` for at least one cycle before it can win again.
- Clearing and a new request from the same master cannot coincide, because `BR[i]` = 0 that cycle.

Outputs:
- `BG` = one-hot of `owner` while in GRANT, else 0.
- `BUS_BUSY` = (state == GRANT).
- `TIMEOUT` is high only during the TURN cycle that follows a revoke.

Simultaneous events:
- A new requester appearing in the same cycle the owner releases is considered at the TURN exit, not earlier.
- `BR` bits of non-owners are ignored while in GRANT. They remain pending as long as they are held.

## Timing
Reset: on a `RST` edge, the following load regardless of state, including mid-grant:
- state = IDLE
- `ptr` = 0, giving master 0 the highest priority
- `owner` = 0
- `hcnt` = 0
- `rmask` = 0
- `BG` = 0, `BUS_BUSY` = 0, `GRANT_ID` = 0, `TIMEOUT` = 0

Request-to-grant latency: `BR[i]` is sampled high at edge n while IDLE, and `BG[i]` is high from edge n (registered output, visible in cycle n+1).

Release: `BR[owner]` is sampled 0 at edge m, and `BG` goes low after edge m. The next grant appears after edge m+1 at the earliest, so there is exactly one dead cycle between owners.

Hold limit: `BG` stays high for at most `MAX_HOLD` consecutive cycles. With `MAX_HOLD`=1, every grant lasts one cycle and is followed by TURN. Whether `TIMEOUT` fires then depends on `BR` being held.

Back-to-back: continuous contention yields a pattern of grant (≥1 cycle), TURN (1 cycle), grant, with no IDLE cycle in between.

## Test plan
- Reset, then `BR`=6'b000100 for 5 cycles, then `BR`=0. Required: `BG`=6'b000100 exactly 5 cycles starting one cycle after the request, then `BG`=0, `GRANT_ID`=2 while busy, `ptr`=3.
- `BR`=6'b111111 held, each owner dropping its request after 3 cycles of grant. Required: grant order 0,1,2,3,4,5,0; every grant 3 cycles long; exactly one `BG`=0 cycle between grants; never two `BG` bits high.
- `ptr`=5 (after granting 4), then `BR`=6'b100001. Required: 5 is granted before 0 (wrap-around); next `ptr`=0.
- `MAX_HOLD`=64, `BR[1]` held forever, `BR[3]` asserted at cycle 10. Required: `BG[1]` high for 64 cycles; `TIMEOUT` pulse for 1 cycle; then `BG[3]` granted; `BR[1]` is not granted again until it drops for ≥1 cycle and reasserts.
- `RST` asserted during cycle 20 of a grant to master 4. Required: `BG`=0, `BUS_BUSY`=0, `TIMEOUT`=0 on the next cycle; with `BR`=6'b110000 still held after reset, master 4 is granted first because `ptr`=0 scans 0..5.
- Owner releases in the same cycle master 2 newly asserts. Required: one TURN cycle with `BG`=0, then `BG[2]`=1.
